// File: rtl/bbpd_loop_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : bbpd_loop_filter_if
// Purpose  : Sample-word and loop-output bundle between sampler and DCO model.
// Revision : 1.0
// ============================================================================
interface bbpd_loop_filter_if #(
    parameter int N_LANES = 8,
    parameter int CODE_W  = 10
);
    logic                     en;
    logic                     smp_valid;
    logic [N_LANES-1:0]       data_smp;
    logic [N_LANES-1:0]       edge_smp;
    logic                     up;
    logic                     down;
    logic signed [CODE_W-1:0] ctrl_code;
    logic                     code_valid;
    logic                     locked;

    modport master (
        output en, smp_valid, data_smp, edge_smp,
        input  up, down, ctrl_code, code_valid, locked
    );

    modport slave (
        input  en, smp_valid, data_smp, edge_smp,
        output up, down, ctrl_code, code_valid, locked
    );
endinterface
`default_nettype wire

// File: rtl/bbpd_loop_filter.sv
`default_nettype none
// ============================================================================
// Module   : bbpd_loop_filter
// Purpose  : Alexander bang-bang PD feeding a saturating PI loop filter that
//            drives a signed DCO code. Lock detector under BBPD_LOCK_DET_EN.
// Revision : 1.0
// ============================================================================
module bbpd_loop_filter #(
    parameter int N_LANES  = 8,
    parameter int CODE_W   = 10,
    parameter int KP_SHIFT = 2,
    parameter int KI_SHIFT = 4,
    parameter int LOCK_TH  = 1,
    parameter int LOCK_CNT = 16
) (
    input wire             refclk,
    input wire             rst_n,
    bbpd_loop_filter_if.slave bus
);
    localparam int NET_W = $clog2(N_LANES) + 2;
    localparam int INT_W = CODE_W + KI_SHIFT;
    localparam int SUM_W = INT_W + KP_SHIFT + NET_W;
    localparam logic signed [SUM_W-1:0] INT_POS  = SUM_W'((2 ** (INT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] INT_NEG  = -INT_POS;
    localparam logic signed [SUM_W-1:0] CODE_POS = SUM_W'((2 ** (CODE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] CODE_NEG = -CODE_POS;

    logic                     d_prev_q, d_prev_d;
    logic signed [NET_W-1:0]  net_q, net_d;
    logic                     up_q, up_d, down_q, down_d;
    logic                     v1_q, v1_d;
    logic signed [INT_W-1:0]  integ_q, integ_d;
    logic signed [CODE_W-1:0] code_q, code_d;
    logic                     cv_q, cv_d;

    logic                     accept;
    logic [N_LANES-1:0]       prev_vec;
    logic signed [NET_W-1:0]  net;
    logic signed [SUM_W-1:0]  int_sum, int_sat, code_sum, code_sat;

    assign accept   = bus.smp_valid & bus.en;
    // Lane i compares against the bit before it in time; lane 0 uses the last bit of the previous word.
    assign prev_vec = {bus.data_smp[N_LANES-2:0], d_prev_q};

    always_comb begin
        net = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (prev_vec[i] != bus.data_smp[i]) begin
                if (bus.edge_smp[i] == bus.data_smp[i])
                    net = net + NET_W'(1);
                else
                    net = net - NET_W'(1);
            end
        end
    end

    always_comb begin
        d_prev_d = d_prev_q;
        net_d    = net_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        v1_d     = 1'b0;
        if (accept) begin
            d_prev_d = bus.data_smp[N_LANES-1];
            net_d    = net;
            up_d     = ~net[NET_W-1] && (net != '0);
            down_d   = net[NET_W-1];
            v1_d     = 1'b1;
        end
    end

    always_comb begin
        int_sum = SUM_W'(integ_q) + SUM_W'(net_q);
        if (int_sum > INT_POS)
            int_sat = INT_POS;
        else if (int_sum < INT_NEG)
            int_sat = INT_NEG;
        else
            int_sat = int_sum;

        // Floor shift can reach one below -CODE_POS; the clamp keeps the code symmetric.
        code_sum = (int_sat >>> KI_SHIFT) + (SUM_W'(net_q) <<< KP_SHIFT);
        if (code_sum > CODE_POS)
            code_sat = CODE_POS;
        else if (code_sum < CODE_NEG)
            code_sat = CODE_NEG;
        else
            code_sat = code_sum;

        integ_d = integ_q;
        code_d  = code_q;
        cv_d    = 1'b0;
        if (v1_q) begin
            integ_d = int_sat[INT_W-1:0];
            code_d  = code_sat[CODE_W-1:0];
            cv_d    = 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            d_prev_q <= 1'b0;
            net_q    <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            v1_q     <= 1'b0;
            integ_q  <= '0;
            code_q   <= '0;
            cv_q     <= 1'b0;
        end else begin
            d_prev_q <= d_prev_d;
            net_q    <= net_d;
            up_q     <= up_d;
            down_q   <= down_d;
            v1_q     <= v1_d;
            integ_q  <= integ_d;
            code_q   <= code_d;
            cv_q     <= cv_d;
        end
    end

    assign bus.up         = up_q;
    assign bus.down       = down_q;
    assign bus.ctrl_code  = code_q;
    assign bus.code_valid = cv_q;

`ifdef BBPD_LOCK_DET_EN
    localparam int LCNT_W = $clog2(LOCK_CNT + 1);
    localparam logic signed [NET_W-1:0] TH_POS = NET_W'(LOCK_TH);
    localparam logic signed [NET_W-1:0] TH_NEG = -TH_POS;

    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              quiet;

    assign quiet = (net_q <= TH_POS) && (net_q >= TH_NEG);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (v1_q) begin
            if (quiet) begin
                if (lock_cnt_q != LCNT_W'(LOCK_CNT))
                    lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                locked_d = (lock_cnt_d == LCNT_W'(LOCK_CNT));
            end else begin
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign bus.locked = locked_q;
`else
    assign bus.locked = 1'b0;
`endif
endmodule
`default_nettype wire
